// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the VGA framebuffer AXI4 slave.
package vga_fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WD    = 2'd2,
    WRESP = 2'd3
  } fb_state_e;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam int unsigned BEAT_BYTES    = 8;
  localparam int unsigned BEAT_SHIFT    = $clog2(BEAT_BYTES);
  localparam logic [7:0]  VGA_BURST_LEN = 8'd199;

  function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
    logic [63:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/fb_rd_fifo.sv
// Two-entry 64-bit read-return FIFO; async active-low clear empties it.
module fb_rd_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [63:0] i_data,
  output logic [63:0] o_data,
  output logic [1:0]  o_count
);

  logic [63:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/vga_fb_slave.sv
// AXI4 slave fronting the framebuffer SRAM: streaming INCR reads for the VGA
// line fetch and strobed burst writes from the CPU, one transaction at a time.
module vga_fb_slave
  import vga_fb_pkg::*;
#(
  parameter int unsigned MEM_AW  = 18,
  parameter int unsigned BASE_AW = 21
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              io_slave_awvalid,
  input  logic [31:0]       io_slave_awaddr,
  input  logic [3:0]        io_slave_awid,
  input  logic [7:0]        io_slave_awlen,
  input  logic [2:0]        io_slave_awsize,
  input  logic [1:0]        io_slave_awburst,
  output logic              io_slave_awready,
  input  logic              io_slave_wvalid,
  input  logic [63:0]       io_slave_wdata,
  input  logic [7:0]        io_slave_wstrb,
  input  logic              io_slave_wlast,
  output logic              io_slave_wready,
  output logic              io_slave_bvalid,
  output logic [1:0]        io_slave_bresp,
  output logic [3:0]        io_slave_bid,
  input  logic              io_slave_bready,
  input  logic              io_slave_arvalid,
  input  logic [31:0]       io_slave_araddr,
  input  logic [3:0]        io_slave_arid,
  input  logic [7:0]        io_slave_arlen,
  input  logic [2:0]        io_slave_arsize,
  input  logic [1:0]        io_slave_arburst,
  output logic              io_slave_arready,
  output logic              io_slave_rvalid,
  output logic [1:0]        io_slave_rresp,
  output logic [63:0]       io_slave_rdata,
  output logic              io_slave_rlast,
  output logic [3:0]        io_slave_rid,
  input  logic              io_slave_rready,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [63:0]       mem_wmask,
  input  logic [63:0]       mem_rdata
);

  fb_state_e          r_state, w_state_nxt;
  logic               r_prio_rd;
  logic [3:0]         r_id;
  logic [7:0]         r_len;
  logic [MEM_AW-1:0]  r_addr;
  logic [8:0]         r_iss;
  logic [7:0]         r_ret;
  logic               r_inflight;

  logic [BASE_AW-1:0] w_ar_off, w_aw_off;
  logic [MEM_AW-1:0]  w_ar_word, w_aw_word;
  logic               w_idle, w_arready, w_awready;
  logic [1:0]         w_fifo_count, w_occ;
  logic [63:0]        w_fifo_data;
  logic               w_rvalid, w_rlast, w_r_hs, w_rd_issue;
  logic               w_unused;

  assign w_ar_off  = io_slave_araddr[BASE_AW-1:0];
  assign w_aw_off  = io_slave_awaddr[BASE_AW-1:0];
  assign w_ar_word = w_ar_off[MEM_AW+BEAT_SHIFT-1:BEAT_SHIFT];
  assign w_aw_word = w_aw_off[MEM_AW+BEAT_SHIFT-1:BEAT_SHIFT];

  assign w_idle    = (r_state == IDLE) & resetn;
  assign w_arready = w_idle & io_slave_arvalid & (r_prio_rd | ~io_slave_awvalid);
  assign w_awready = w_idle & io_slave_awvalid & ~w_arready;

  assign w_rvalid   = (w_fifo_count != '0);
  assign w_r_hs     = w_rvalid & io_slave_rready;
  assign w_rlast    = w_rvalid & (r_ret == r_len);
  assign w_occ      = w_fifo_count + {1'b0, r_inflight};
  // A beat popped this cycle frees its slot, so issue may refill it at once.
  assign w_rd_issue = (r_state == RD) & (r_iss <= {1'b0, r_len}) &
                      ((w_occ < 2'd2) | w_r_hs);

  always_comb begin
    w_state_nxt = r_state;
    mem_cen     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    case (r_state)
      IDLE: begin
        // Beat 0 is read during the AR handshake so rvalid rises two cycles later.
        if (w_arready) begin
          w_state_nxt = RD;
          mem_cen     = 1'b1;
          mem_addr    = w_ar_word;
        end else if (w_awready) begin
          w_state_nxt = WD;
        end
      end
      RD: begin
        mem_addr = r_addr;
        mem_cen  = w_rd_issue;
        if (w_r_hs && w_rlast) w_state_nxt = IDLE;
      end
      WD: begin
        mem_addr = r_addr;
        if (io_slave_wvalid) begin
          mem_cen   = 1'b1;
          mem_wen   = 1'b1;
          mem_wdata = io_slave_wdata;
          mem_wmask = strb_to_mask(io_slave_wstrb);
          if (io_slave_wlast) w_state_nxt = WRESP;
        end
      end
      WRESP: begin
        if (io_slave_bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_prio_rd  <= 1'b1;
      r_id       <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_iss      <= '0;
      r_ret      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_arready | w_rd_issue;
      case (r_state)
        IDLE: begin
          if (w_arready) begin
            r_prio_rd <= 1'b0;
            r_id      <= io_slave_arid;
            r_len     <= io_slave_arlen;
            r_addr    <= w_ar_word + MEM_AW'(1);
            r_iss     <= 9'd1;
            r_ret     <= '0;
          end else if (w_awready) begin
            r_prio_rd <= 1'b1;
            r_id      <= io_slave_awid;
            r_addr    <= w_aw_word;
          end
        end
        RD: begin
          if (w_rd_issue) begin
            r_addr <= r_addr + MEM_AW'(1);
            r_iss  <= r_iss + 9'd1;
          end
          if (w_r_hs) r_ret <= r_ret + 8'd1;
        end
        WD: begin
          if (io_slave_wvalid) r_addr <= r_addr + MEM_AW'(1);
        end
        default: ;
      endcase
    end
  end

  fb_rd_fifo u_rd_fifo (
    .clk     (clock),
    .rst_n   (resetn),
    .i_push  (r_inflight),
    .i_pop   (w_r_hs),
    .i_data  (mem_rdata),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  assign io_slave_arready = w_arready;
  assign io_slave_awready = w_awready;
  assign io_slave_wready  = (r_state == WD);
  assign io_slave_bvalid  = (r_state == WRESP);
  assign io_slave_bresp   = RESP_OKAY;
  assign io_slave_bid     = r_id;
  assign io_slave_rvalid  = w_rvalid;
  assign io_slave_rdata   = w_fifo_data;
  assign io_slave_rresp   = RESP_OKAY;
  assign io_slave_rlast   = w_rlast;
  assign io_slave_rid     = r_id;

  assign w_unused = ^{io_slave_awlen, io_slave_awsize, io_slave_awburst,
                      io_slave_arsize, io_slave_arburst,
                      io_slave_araddr[31:BASE_AW], io_slave_awaddr[31:BASE_AW],
                      w_ar_off[BEAT_SHIFT-1:0], w_aw_off[BEAT_SHIFT-1:0]};

endmodule
